// File: rtl/secret_ret_guard_if.sv
// secret_ret_guard_if: call/return request and validated-return result bundle for the shadow-stack guard.
interface secret_ret_guard_if #(
    parameter int DEPTH = 16,
    parameter int AW    = 64
);
    logic                       call_valid;
    logic [AW-1:0]              call_ret_addr;
    logic                       ret_valid;
    logic [AW-1:0]              ret_addr;
    logic                       o_valid;
    logic [AW-1:0]              o;
    logic                       fault;
    logic                       overflow;
    logic                       underflow;
    logic [$clog2(DEPTH):0]     depth;

    modport master (
        output call_valid, call_ret_addr, ret_valid, ret_addr,
        input  o_valid, o, fault, overflow, underflow, depth
    );

    modport slave (
        input  call_valid, call_ret_addr, ret_valid, ret_addr,
        output o_valid, o, fault, overflow, underflow, depth
    );
endinterface

// File: rtl/secret_ret_guard.sv
// secret_ret_guard: hardware shadow stack; returns matching the pushed address pass through, anything else is zeroed and faulted.
module secret_ret_guard #(
    parameter int DEPTH = 16,
    parameter int AW    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    secret_ret_guard_if.slave   bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int SW = IW + 1;

    logic [AW-1:0] r_mem [DEPTH];
    logic [SW-1:0] r_sp;
    logic          r_ovf;
    logic          r_udf;
    logic          r_ov;
    logic [AW-1:0] r_o;
    logic          r_fault;

    logic          w_empty;
    logic          w_full;
    logic [IW-1:0] w_top_idx;
    logic          w_match;
    logic          w_we;
    logic [IW-1:0] w_widx;
    logic [SW-1:0] w_sp_nxt;

    assign w_empty   = r_sp == '0;
    assign w_full    = r_sp == SW'(DEPTH);
    assign w_top_idx = IW'(r_sp - 1'b1);
    // Once overflow is seen the stack is untrusted, so no return can match again.
    assign w_match   = !w_empty && !r_ovf && (bus.ret_addr == r_mem[w_top_idx]);
    // A simultaneous call overwrites the slot the return just consumed.
    assign w_we      = bus.call_valid && (bus.ret_valid || !w_full);
    assign w_widx    = (bus.ret_valid && !w_empty) ? w_top_idx : r_sp[IW-1:0];
    assign w_sp_nxt  = (bus.call_valid && (bus.ret_valid ? w_empty : !w_full)) ? r_sp + 1'b1 :
                       (bus.ret_valid && !bus.call_valid && !w_empty) ? r_sp - 1'b1 : r_sp;

    always_ff @(posedge clk) begin
        if (rst_n && w_we)
            r_mem[w_widx] <= bus.call_ret_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_ov    <= 1'b0;
            r_o     <= '0;
            r_fault <= 1'b0;
        end else begin
            r_sp    <= w_sp_nxt;
            r_ov    <= bus.ret_valid;
            r_o     <= (bus.ret_valid && w_match) ? bus.ret_addr : '0;
            r_fault <= bus.ret_valid && !w_match;
            if (bus.ret_valid && w_empty)
                r_udf <= 1'b1;
            if (bus.call_valid && !bus.ret_valid && w_full)
                r_ovf <= 1'b1;
        end
    end

    assign bus.o_valid   = r_ov;
    assign bus.o         = r_o;
    assign bus.fault     = r_fault;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_udf;
    assign bus.depth     = r_sp;
endmodule
